// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - packet-aware router output FIFO with header tagging and occupancy.
// Optional almost_full output enabled by defining ROUTER_FIFO_ALMOST_FULL_EN.
module router_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_SIZE  = 4,
  parameter int AF_THRESH  = 14
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  output logic                  pkt_last,
  output logic                  pkt_err,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_SIZE:0]    occupancy,
  output logic                  almost_full
);

  localparam logic [ADDR_SIZE:0]    PTR_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-2:0] CNT_ONE = {{(DATA_WIDTH-2){1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0]    AF_LVL  = AF_THRESH[ADDR_SIZE:0];

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_SIZE:0]    wr_ptr, rd_ptr;
  logic [DATA_WIDTH-2:0] pkt_cnt;
  logic [DATA_WIDTH:0]   rd_word;
  logic                  wr_en, rd_en;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]) &&
                     (wr_ptr[ADDR_SIZE-1:0] == rd_ptr[ADDR_SIZE-1:0]);
  assign occupancy = wr_ptr - rd_ptr;

  // soft_reset discards any read or write presented in the same cycle
  assign wr_en   = write_enb && !full && !soft_reset;
  assign rd_en   = read_enb && !empty && !soft_reset;
  assign rd_word = mem[rd_ptr[ADDR_SIZE-1:0]];

`ifdef ROUTER_FIFO_ALMOST_FULL_EN
  assign almost_full = (occupancy >= AF_LVL);
`else
  logic unused_af;
  assign unused_af   = ^AF_LVL;
  assign almost_full = 1'b0;
`endif

  // Storage is deliberately left out of reset
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[ADDR_SIZE-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out   <= '0;
      pkt_cnt    <= '0;
      read_valid <= 1'b0;
      pkt_last   <= 1'b0;
      pkt_err    <= 1'b0;
    end else if (soft_reset) begin
      data_out   <= '0;
      pkt_cnt    <= '0;
      read_valid <= 1'b0;
      pkt_last   <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      read_valid <= rd_en;
      pkt_last   <= 1'b0;
      pkt_err    <= 1'b0;
      if (rd_en) begin
        data_out <= rd_word[DATA_WIDTH-1:0];
        if (rd_word[DATA_WIDTH]) begin
          // header reload counts payload plus the trailing parity byte
          pkt_cnt <= {1'b0, rd_word[DATA_WIDTH-1:2]} + CNT_ONE;
          pkt_err <= (pkt_cnt != '0);
        end else if (pkt_cnt > CNT_ONE) begin
          pkt_cnt <= pkt_cnt - CNT_ONE;
        end else if (pkt_cnt == CNT_ONE) begin
          pkt_cnt  <= '0;
          pkt_last <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - directed self-checking bench for router_pkt_fifo.
module tb_router_pkt_fifo;

  logic       clock = 1'b0;
  logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       read_valid, pkt_last, pkt_err, full, empty, almost_full;
  logic [4:0] occupancy;

  int checks = 0;
  int errors = 0;

  router_pkt_fifo dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .read_valid(read_valid),
    .pkt_last(pkt_last), .pkt_err(pkt_err), .full(full), .empty(empty),
    .occupancy(occupancy), .almost_full(almost_full)
  );

  always #5 clock = ~clock;

  task automatic cyc(input logic we, input logic re, input logic lfd, input logic [7:0] d);
    write_enb = we; read_enb = re; lfd_state = lfd; data_in = d;
    @(posedge clock); #1;
    write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
  endtask

  function automatic logic af_exp(input int occ);
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
    return (occ >= 14);
`else
    return (occ < 0);
`endif
  endfunction

  task automatic test_reset;
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out); end
    checks++; if ({read_valid, pkt_last, pkt_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {read_valid, pkt_last, pkt_err}); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(i));
      checks++; if (occupancy !== 5'(i)) begin errors++; $display("FAIL fill_occ[%0d] got %0d exp %0d", i, occupancy, i); end
      checks++; if (almost_full !== af_exp(i)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, af_exp(i)); end
      checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 16)); end
    end
    cyc(1'b1, 1'b0, 1'b0, 8'hFF);
    checks++; if (occupancy !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL drop_write occ %0d full %b exp 16 1", occupancy, full); end
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (data_out !== 8'(i) || read_valid !== 1'b1) begin errors++; $display("FAIL drain[%0d] data %h rv %b exp %h 1", i, data_out, read_valid, 8'(i)); end
      checks++; if (pkt_last !== 1'b0 || pkt_err !== 1'b0) begin errors++; $display("FAIL drain_flags[%0d] last %b err %b exp 0 0", i, pkt_last, pkt_err); end
      checks++; if (almost_full !== af_exp(16 - i)) begin errors++; $display("FAIL drain_af[%0d] got %b exp %b", i, almost_full, af_exp(16 - i)); end
    end
    checks++; if (empty !== 1'b1 || occupancy !== 5'd0) begin errors++; $display("FAIL drained empty %b occ %0d exp 1 0", empty, occupancy); end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (read_valid !== 1'b0 || data_out !== 8'h10) begin errors++; $display("FAIL empty_read rv %b data %h exp 0 10", read_valid, data_out); end
  endtask

  task automatic test_packet;
    logic [7:0] bytes [5];
    logic       lasts [5];
    bytes = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'hAA};
    lasts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, (i == 0), bytes[i]);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (data_out !== bytes[i] || read_valid !== 1'b1) begin errors++; $display("FAIL pkt_data[%0d] got %h rv %b exp %h 1", i, data_out, read_valid, bytes[i]); end
      checks++; if (pkt_last !== lasts[i] || pkt_err !== 1'b0) begin errors++; $display("FAIL pkt_flags[%0d] last %b err %b exp %b 0", i, pkt_last, pkt_err, lasts[i]); end
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
    cyc(1'b1, 1'b1, 1'b0, 8'h99);
    checks++; if (data_out !== 8'h40 || read_valid !== 1'b1) begin errors++; $display("FAIL rw_full data %h rv %b exp 40 1", data_out, read_valid); end
    checks++; if (occupancy !== 5'd15 || full !== 1'b0) begin errors++; $display("FAIL rw_full_occ %0d full %b exp 15 0", occupancy, full); end
    for (int i = 1; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (data_out !== 8'h4F || empty !== 1'b1) begin errors++; $display("FAIL rw_drain data %h empty %b exp 4F 1", data_out, empty); end
    cyc(1'b1, 1'b1, 1'b0, 8'h77);
    checks++; if (read_valid !== 1'b0 || occupancy !== 5'd1) begin errors++; $display("FAIL rw_empty rv %b occ %0d exp 0 1", read_valid, occupancy); end
    cyc(1'b1, 1'b1, 1'b0, 8'h78);
    checks++; if (data_out !== 8'h77 || read_valid !== 1'b1 || occupancy !== 5'd1) begin errors++; $display("FAIL rw_mid data %h rv %b occ %0d exp 77 1 1", data_out, read_valid, occupancy); end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (data_out !== 8'h78 || empty !== 1'b1) begin errors++; $display("FAIL rw_last data %h empty %b exp 78 1", data_out, empty); end
  endtask

  task automatic test_pkt_err;
    logic [7:0] bytes [6];
    logic [2:0] flags [6];
    bytes = '{8'h14, 8'h01, 8'h02, 8'h04, 8'h55, 8'hAB};
    flags = '{3'b100, 3'b100, 3'b100, 3'b101, 3'b100, 3'b110};
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, (i == 0 || i == 3), bytes[i]);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if ({read_valid, pkt_last, pkt_err} !== flags[i] || data_out !== bytes[i]) begin errors++; $display("FAIL err_seq[%0d] rv/last/err %b data %h exp %b %h", i, {read_valid, pkt_last, pkt_err}, data_out, flags[i], bytes[i]); end
    end
  endtask

  task automatic test_soft_reset;
    cyc(1'b1, 1'b0, 1'b1, 8'h20);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (occupancy !== 5'd7 || data_out !== 8'h20) begin errors++; $display("FAIL sr_pre occ %0d data %h exp 7 20", occupancy, data_out); end
    soft_reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 8'hEE);
    soft_reset = 1'b0;
    checks++; if (empty !== 1'b1 || occupancy !== 5'd0 || data_out !== 8'h00) begin errors++; $display("FAIL sr_clear empty %b occ %0d data %h exp 1 0 00", empty, occupancy, data_out); end
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL sr_rv got %b exp 0", read_valid); end
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h66);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (pkt_err !== 1'b0 || pkt_last !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL sr_hdr err %b last %b data %h exp 0 0 00", pkt_err, pkt_last, data_out); end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (pkt_last !== 1'b1 || data_out !== 8'h66) begin errors++; $display("FAIL sr_len0 last %b data %h exp 1 66", pkt_last, data_out); end
  endtask

  task automatic test_hard_reset;
    cyc(1'b1, 1'b0, 1'b0, 8'h3C);
    cyc(1'b1, 1'b0, 1'b0, 8'h5A);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (data_out !== 8'h3C || occupancy !== 5'd1) begin errors++; $display("FAIL hr_pre data %h occ %0d exp 3C 1", data_out, occupancy); end
    write_enb = 1'b1; data_in = 8'hC3;
    #2 resetn = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || occupancy !== 5'd0 || full !== 1'b0) begin errors++; $display("FAIL hr_async empty %b occ %0d full %b exp 1 0 0", empty, occupancy, full); end
    checks++; if (data_out !== 8'h00 || read_valid !== 1'b0) begin errors++; $display("FAIL hr_async_data %h rv %b exp 00 0", data_out, read_valid); end
    write_enb = 1'b0; data_in = 8'h00;
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hr_after empty %b exp 1", empty); end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_packet;
    test_simultaneous;
    test_pkt_err;
    test_soft_reset;
    test_hard_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
- Parametrised, packet-aware successor to the router's per-channel output FIFO.
- Stores data bytes with a header tag, written while the FSM is in load-first-data (lfd_state).
- Tracks packet boundaries on the read side, flags the last byte (parity) of each packet, and reports occupancy.
- Sits between the router FSM/register block and each output channel of the 1x3 router.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out; header payload length occupies bits [DATA_WIDTH-1:2].
- DEPTH, 16, number of entries; must be a power of 2.
- ADDR_SIZE, 4, log2(DEPTH); pointers are ADDR_SIZE+1 bits.
- AF_THRESH, 14, occupancy at or above which almost_full asserts (optional feature only).

Ports:
- clock  input  1  single clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- soft_reset  input  1  synchronous active-high flush, e.g. on channel timeout.
- write_enb  input  1  active-high write request.
- read_enb  input  1  active-high read request.
- lfd_state  input  1  marks the current write as a header byte.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- read_valid  output  1  data_out holds a newly read byte (one-cycle pulse).
- pkt_last  output  1  qualifies read_valid: the byte is the final (parity) byte of a packet.
- pkt_err  output  1  one-cycle pulse: header read while the previous packet is incomplete.
- full  output  1  FIFO full.
- empty  output  1  FIFO empty.
- occupancy  output  ADDR_SIZE+1  number of stored entries, 0..DEPTH.
- almost_full  output  1  occupancy >= AF_THRESH (optional feature).

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1). Bit DATA_WIDTH holds lfd_state, captured at write time.
- Pointers: wr_ptr and rd_ptr, ADDR_SIZE+1 bits, natural wrap; the low ADDR_SIZE bits index memory.
- Flags and occupancy (combinational from registered pointers):
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits equal.
  - occupancy = wr_ptr - rd_ptr, modulo 2^(ADDR_SIZE+1).
- Write: accepted when write_enb && !full; stores {lfd_state, data_in}; wr_ptr+1. A write while full is dropped; no state change.
- Read: accepted when read_enb && !empty; rd_ptr+1. A read while empty does nothing and read_valid stays 0.
- Read latency: 1 cycle. data_out, read_valid, pkt_last and pkt_err update on the edge that accepts the read. data_out holds its value when no read occurs.
- Simultaneous read and write:
  - Flags are those sampled before the edge.
  - When full, the read proceeds and the write is dropped.
  - When empty, the write proceeds and the read is ignored.
  - Otherwise both proceed and occupancy is unchanged.
- Packet counter pkt_cnt (DATA_WIDTH-1 bits), evaluated on each accepted read:
  - Tag=1 (header): pkt_cnt <= data[DATA_WIDTH-1:2] + 1 (payload + parity); pkt_last=0; pkt_err=1 if the old pkt_cnt != 0.
  - Tag=0 and pkt_cnt > 1: decrement; pkt_last=0.
  - Tag=0 and pkt_cnt == 1: pkt_cnt <= 0; pkt_last=1.
  - Tag=0 and pkt_cnt == 0 (stray byte): byte is delivered; pkt_last=0; pkt_cnt stays 0.
  - Header with length 0: pkt_cnt=1, so the next data byte is last.
- Reset, async (resetn=0):
  - Pointers, pkt_cnt, data_out=0; read_valid, pkt_last, pkt_err=0; empty=1, full=0, occupancy=0.
  - Memory contents are not cleared.
  - Deassertion is synchronised externally.
- soft_reset: same clearing as resetn, synchronous.
  - Priority: resetn > soft_reset > read/write. Writes and reads in the same cycle are discarded.
  - Asserting it mid-packet discards all contents; the next header starts cleanly with no pkt_err.

Optional Feature:
- ROUTER_FIFO_ALMOST_FULL_EN defined: almost_full = (occupancy >= AF_THRESH), combinational; clears with the pointers on reset and soft_reset.
- Not defined: almost_full tied to 0 and AF_THRESH unused. All other behaviour is identical.

Test Plan:
- Reset then 16 writes of 0x01..0x10 (lfd=0) -> full=1 after the 16th, occupancy=16; 17th write 0xFF dropped; 16 reads return 0x01..0x10 in order with read_valid each cycle; then empty=1.
- Header 0x0C (len 3, lfd=1) + 3 payload bytes + parity 0xAA written, then 5 reads -> pkt_last=1 only on the 0xAA read, pkt_err=0.
- Fill to occupancy 16, then assert write and read together -> read returns the oldest byte, write dropped, occupancy=15. Then at occupancy 0 with both asserted -> write accepted, no read_valid, occupancy=1.
- Header len 5 followed by only 2 bytes, then header 0x04 (len 1) -> pkt_err pulses on the second header read; pkt_cnt reloads to 2; pkt_last appears 2 reads later.
- Mid-packet soft_reset with occupancy 7 -> next cycle empty=1, occupancy=0, data_out=0; a resetn pulse mid-write clears everything asynchronously, before the next edge.
- With ROUTER_FIFO_ALMOST_FULL_EN: almost_full rises on the 14th write and falls when occupancy drops to 13. Without the macro: almost_full stays 0 throughout.
